// File: rtl/usart_core_if.sv
// Consumer-side handshake bundle for usart_core: TX push port, RX pop port, error pulses.
interface usart_core_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_frame_err;
  logic                 rx_parity_err;
  logic                 rx_overrun;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
  );
endinterface

// File: rtl/usart_core.sv
// Parametrised full-duplex UART with a FIFO on each direction and
// framing/parity/overrun reporting.
module usart_core #(
  parameter int CLOCKS_PER_BIT  = 2604,
  parameter int DATA_BITS       = 8,
  parameter int PARITY_MODE     = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        RXD,
  output logic        TXD,
  usart_core_if.slave bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = $clog2(CLOCKS_PER_BIT * STOP_BITS + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_END = CW'(CLOCKS_PER_BIT * STOP_BITS - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [FIFO_DEPTH_LOG2:0] FULL = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0]       r_txf_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_txf_wp, r_txf_rp;
  logic [FIFO_DEPTH_LOG2:0]   r_txf_cnt, w_txf_cnt_nxt;
  logic                       r_tx_ready;
  logic                       w_tx_push, w_tx_pop;
  logic [DATA_BITS-1:0]       w_tx_head;

  assign w_tx_push    = bus.tx_valid & r_tx_ready;
  assign w_tx_head    = r_txf_mem[r_txf_rp];
  assign bus.tx_ready = r_tx_ready;

  always_comb begin
    w_txf_cnt_nxt = r_txf_cnt;
    if (w_tx_push && !w_tx_pop)      w_txf_cnt_nxt = r_txf_cnt + 1'b1;
    else if (!w_tx_push && w_tx_pop) w_txf_cnt_nxt = r_txf_cnt - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_txf_wp   <= '0;
      r_txf_rp   <= '0;
      r_txf_cnt  <= '0;
      r_tx_ready <= 1'b1;
    end else begin
      if (w_tx_push) begin
        r_txf_mem[r_txf_wp] <= bus.tx_data;
        r_txf_wp            <= r_txf_wp + 1'b1;
      end
      if (w_tx_pop) r_txf_rp <= r_txf_rp + 1'b1;
      r_txf_cnt  <= w_txf_cnt_nxt;
      r_tx_ready <= (w_txf_cnt_nxt != FULL);
    end
  end

  // ---------------- TX FSM ----------------
  logic [2:0]           r_tx_state;
  logic [CW-1:0]        r_tx_cnt;
  logic [2:0]           r_tx_bit;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par, r_txd;
  logic                 w_tx_bit_done, w_tx_stop_done;

  assign w_tx_bit_done  = (r_tx_cnt == BIT_END);
  assign w_tx_stop_done = (r_tx_cnt == STOP_END);
  assign w_tx_pop = (r_txf_cnt != '0) &&
                    ((r_tx_state == S_IDLE) || (r_tx_state == S_STOP && w_tx_stop_done));
  assign TXD = r_txd;

  // TXD is registered from the current state, so the line lags the FSM by one cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_txd      <= 1'b1;
    end else begin
      case (r_tx_state)
        S_START:  r_txd <= 1'b0;
        S_DATA:   r_txd <= r_tx_shift[0];
        S_PARITY: r_txd <= r_tx_par;
        default:  r_txd <= 1'b1;
      endcase
      r_tx_cnt <= r_tx_cnt + 1'b1;
      if (w_tx_pop) begin
        r_tx_shift <= w_tx_head;
        r_tx_par   <= (PARITY_MODE == 1) ? ~^w_tx_head : ^w_tx_head;
        r_tx_state <= S_START;
        r_tx_cnt   <= '0;
      end else begin
        case (r_tx_state)
          S_IDLE: r_tx_cnt <= '0;
          S_START: if (w_tx_bit_done) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_state <= S_DATA;
          end
          S_DATA: if (w_tx_bit_done) begin
            r_tx_cnt   <= '0;
            r_tx_shift <= r_tx_shift >> 1;
            if (r_tx_bit == LAST_BIT) r_tx_state <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            else                      r_tx_bit   <= r_tx_bit + 1'b1;
          end
          S_PARITY: if (w_tx_bit_done) begin
            r_tx_cnt   <= '0;
            r_tx_state <= S_STOP;
          end
          S_STOP: if (w_tx_stop_done) begin
            r_tx_cnt   <= '0;
            r_tx_state <= S_IDLE;
          end
          default: r_tx_state <= S_IDLE;
        endcase
      end
    end
  end

  // ---------------- RX synchroniser + FSM ----------------
  logic                 r_rx_s1, r_rx_s2, w_rxs;
  logic [2:0]           r_rx_state;
  logic [CW-1:0]        r_rx_cnt;
  logic [2:0]           r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_par;
  logic                 r_frame_err, r_parity_err, r_overrun;
  logic                 w_rx_bit_done, w_rx_stop_smp, w_rx_par_ok, w_rxf_full;
  logic                 w_rx_push, w_rx_pop;

  assign w_rxs         = r_rx_s2;
  assign w_rx_bit_done = (r_rx_cnt == BIT_END);
  assign w_rx_stop_smp = (r_rx_state == S_STOP) && w_rx_bit_done;
  assign w_rx_par_ok   = (PARITY_MODE == 0) ? 1'b1 :
                         (PARITY_MODE == 1) ? r_rx_par : ~r_rx_par;
  assign w_rx_push     = w_rx_stop_smp && w_rxs && w_rx_par_ok && !w_rxf_full;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rx_s1      <= 1'b1;
      r_rx_s2      <= 1'b1;
      r_rx_state   <= S_IDLE;
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_rx_par     <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_rx_s1      <= RXD;
      r_rx_s2      <= r_rx_s1;
      r_frame_err  <= w_rx_stop_smp && !w_rxs;
      r_parity_err <= w_rx_stop_smp && w_rxs && !w_rx_par_ok;
      r_overrun    <= w_rx_stop_smp && w_rxs && w_rx_par_ok && w_rxf_full;
      r_rx_cnt     <= r_rx_cnt + 1'b1;
      case (r_rx_state)
        S_IDLE: begin
          r_rx_cnt <= '0;
          if (!w_rxs) begin
            r_rx_state <= S_START;
            r_rx_bit   <= '0;
            r_rx_par   <= 1'b0;
          end
        end
        S_START: if (r_rx_cnt == HALF_END) begin
          r_rx_cnt   <= '0;
          r_rx_state <= w_rxs ? S_IDLE : S_DATA;
        end
        S_DATA: if (w_rx_bit_done) begin
          r_rx_cnt   <= '0;
          r_rx_shift <= {w_rxs, r_rx_shift[DATA_BITS-1:1]};
          r_rx_par   <= r_rx_par ^ w_rxs;
          if (r_rx_bit == LAST_BIT) r_rx_state <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          else                      r_rx_bit   <= r_rx_bit + 1'b1;
        end
        S_PARITY: if (w_rx_bit_done) begin
          r_rx_cnt   <= '0;
          r_rx_par   <= r_rx_par ^ w_rxs;
          r_rx_state <= S_STOP;
        end
        S_STOP: if (w_rx_bit_done) begin
          r_rx_cnt   <= '0;
          r_rx_state <= S_IDLE;
        end
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO (first-word fall-through) ----------------
  logic [DATA_BITS-1:0]       r_rxf_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_rxf_wp, r_rxf_rp;
  logic [FIFO_DEPTH_LOG2:0]   r_rxf_cnt;

  assign w_rxf_full        = (r_rxf_cnt == FULL);
  assign w_rx_pop          = bus.rx_ready && (r_rxf_cnt != '0);
  assign bus.rx_valid      = (r_rxf_cnt != '0);
  assign bus.rx_data       = r_rxf_mem[r_rxf_rp];
  assign bus.rx_frame_err  = r_frame_err;
  assign bus.rx_parity_err = r_parity_err;
  assign bus.rx_overrun    = r_overrun;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rxf_wp  <= '0;
      r_rxf_rp  <= '0;
      r_rxf_cnt <= '0;
    end else begin
      if (w_rx_push) begin
        r_rxf_mem[r_rxf_wp] <= r_rx_shift;
        r_rxf_wp            <= r_rxf_wp + 1'b1;
      end
      if (w_rx_pop) r_rxf_rp <= r_rxf_rp + 1'b1;
      if (w_rx_push && !w_rx_pop)      r_rxf_cnt <= r_rxf_cnt + 1'b1;
      else if (!w_rx_push && w_rx_pop) r_rxf_cnt <= r_rxf_cnt - 1'b1;
    end
  end
endmodule
